// File: rtl/spu_wb_regfile.sv
// SPU register file: 128 x 128-bit registers with writeback bypass
// and a per-register countdown scoreboard for RAW issue stalls.

module spu_wb_regfile_bank (
   input  logic         clk,
   input  logic         reset,
   input  logic [0:127] wb_rt,
   input  logic [0:6]   wb_rt_addr,
   input  logic         wb_reg_write,
   input  logic [0:6]   ra_addr,
   input  logic [0:6]   rb_addr,
   input  logic [0:6]   rc_addr,
   output logic [0:127] ra,
   output logic [0:127] rb,
   output logic [0:127] rc
);

   logic [0:127] regs [128];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_reg_write) begin
         regs[wb_rt_addr] <= wb_rt;
      end
   end

   logic hit_a;
   logic hit_b;
   logic hit_c;

   assign hit_a = wb_reg_write && (wb_rt_addr == ra_addr);
   assign hit_b = wb_reg_write && (wb_rt_addr == rb_addr);
   assign hit_c = wb_reg_write && (wb_rt_addr == rc_addr);

   // A writeback landing this cycle is visible to readers immediately.
   always_comb begin
      ra = regs[ra_addr];
      rb = regs[rb_addr];
      rc = regs[rc_addr];
      if (hit_a) ra = wb_rt;
      if (hit_b) rb = wb_rt;
      if (hit_c) rc = wb_rt;
   end

endmodule

module spu_wb_regfile_sb #(
   parameter int unsigned LATENCY = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       issue_valid,
   input  logic       issue_reg_write,
   input  logic [0:6] issue_rt_addr,
   input  logic [0:2] issue_use,
   input  logic [0:6] ra_addr,
   input  logic [0:6] rb_addr,
   input  logic [0:6] rc_addr,
   input  logic       flush,
   output logic       stall,
   output logic       busy_any
);

   localparam logic [2:0] LOAD = 3'(LATENCY);

   logic [2:0] cnt [128];
   logic       haz_a;
   logic       haz_b;
   logic       haz_c;
   logic       live;
   logic       accept;

   // cnt==1 means the result is on the writeback port now; bypass covers it.
   assign haz_a = issue_use[0] && (cnt[ra_addr] > 3'd1);
   assign haz_b = issue_use[1] && (cnt[rb_addr] > 3'd1);
   assign haz_c = issue_use[2] && (cnt[rc_addr] > 3'd1);

   assign live   = issue_valid && !flush;
   assign stall  = live && (haz_a || haz_b || haz_c);
   assign accept = live && !stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) begin
            cnt[i] <= 3'd0;
         end
      end else begin
         for (int i = 0; i < 128; i++) begin
            if (cnt[i] != 3'd0) cnt[i] <= cnt[i] - 3'd1;
         end
         // Later assignment wins: a new issue reloads over the decrement.
         if (accept && issue_reg_write) begin
            cnt[issue_rt_addr] <= LOAD;
         end
      end
   end

   always_comb begin
      busy_any = 1'b0;
      for (int i = 0; i < 128; i++) begin
         if (cnt[i] != 3'd0) busy_any = 1'b1;
      end
   end

endmodule

module spu_wb_regfile #(
   parameter int unsigned LATENCY = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         issue_valid,
   input  logic         issue_reg_write,
   input  logic [0:6]   issue_rt_addr,
   input  logic [0:2]   issue_use,
   input  logic [0:6]   ra_addr,
   input  logic [0:6]   rb_addr,
   input  logic [0:6]   rc_addr,
   input  logic         flush,
   input  logic [0:127] wb_rt,
   input  logic [0:6]   wb_rt_addr,
   input  logic         wb_reg_write,
   output logic [0:127] ra,
   output logic [0:127] rb,
   output logic [0:127] rc,
   output logic         stall,
   output logic         busy_any
);

   spu_wb_regfile_bank u_bank (
      .clk          (clk),
      .reset        (reset),
      .wb_rt        (wb_rt),
      .wb_rt_addr   (wb_rt_addr),
      .wb_reg_write (wb_reg_write),
      .ra_addr      (ra_addr),
      .rb_addr      (rb_addr),
      .rc_addr      (rc_addr),
      .ra           (ra),
      .rb           (rb),
      .rc           (rc)
   );

   spu_wb_regfile_sb #(
      .LATENCY (LATENCY)
   ) u_sb (
      .clk             (clk),
      .reset           (reset),
      .issue_valid     (issue_valid),
      .issue_reg_write (issue_reg_write),
      .issue_rt_addr   (issue_rt_addr),
      .issue_use       (issue_use),
      .ra_addr         (ra_addr),
      .rb_addr         (rb_addr),
      .rc_addr         (rc_addr),
      .flush           (flush),
      .stall           (stall),
      .busy_any        (busy_any)
   );

endmodule

// File: tb/tb_spu_wb_regfile.sv
// Bench for spu_wb_regfile: directed hazard scenarios then random
// traffic against a due-cycle reference model.

module tb_spu_wb_regfile;

   localparam int L = 4;

   logic         clk;
   logic         reset;
   logic         issue_valid;
   logic         issue_reg_write;
   logic [0:6]   issue_rt_addr;
   logic [0:2]   issue_use;
   logic [0:6]   ra_addr;
   logic [0:6]   rb_addr;
   logic [0:6]   rc_addr;
   logic         flush;
   logic [0:127] wb_rt;
   logic [0:6]   wb_rt_addr;
   logic         wb_reg_write;
   logic [0:127] ra;
   logic [0:127] rb;
   logic [0:127] rc;
   logic         stall;
   logic         busy_any;

   spu_wb_regfile #(.LATENCY(L)) dut (
      .clk             (clk),
      .reset           (reset),
      .issue_valid     (issue_valid),
      .issue_reg_write (issue_reg_write),
      .issue_rt_addr   (issue_rt_addr),
      .issue_use       (issue_use),
      .ra_addr         (ra_addr),
      .rb_addr         (rb_addr),
      .rc_addr         (rc_addr),
      .flush           (flush),
      .wb_rt           (wb_rt),
      .wb_rt_addr      (wb_rt_addr),
      .wb_reg_write    (wb_reg_write),
      .ra              (ra),
      .rb              (rb),
      .rc              (rc),
      .stall           (stall),
      .busy_any        (busy_any)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: register contents plus the cycle in which each pending
   // register's writeback appears. Stall while now is before that cycle.
   logic [0:127] mem [128];
   longint       due [128];
   longint       cyc;
   int           vecs;
   int           errs;

   function automatic logic [0:127] m_read(input logic [0:6] a);
      if (wb_reg_write && wb_rt_addr == a) return wb_rt;
      return mem[a];
   endfunction

   function automatic logic m_stall();
      logic h;
      h = 1'b0;
      if (issue_use[0] && cyc < due[ra_addr]) h = 1'b1;
      if (issue_use[1] && cyc < due[rb_addr]) h = 1'b1;
      if (issue_use[2] && cyc < due[rc_addr]) h = 1'b1;
      return issue_valid && !flush && h;
   endfunction

   function automatic logic m_busy();
      for (int i = 0; i < 128; i++) begin
         if (cyc <= due[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [0:127] obs,
                      input logic [0:127] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("stall", 128'(stall), 128'(m_stall()));
      chk("busy_any", 128'(busy_any), 128'(m_busy()));
      chk("ra", ra, m_read(ra_addr));
      chk("rb", rb, m_read(rb_addr));
      chk("rc", rc, m_read(rc_addr));
   endtask

   task automatic idle();
      reset           = 1'b0;
      issue_valid     = 1'b0;
      issue_reg_write = 1'b0;
      issue_rt_addr   = '0;
      issue_use       = '0;
      ra_addr         = '0;
      rb_addr         = '0;
      rc_addr         = '0;
      flush           = 1'b0;
      wb_rt           = '0;
      wb_rt_addr      = '0;
      wb_reg_write    = 1'b0;
   endtask

   task automatic issue(input logic [0:6] rt, input logic rw,
                        input logic [0:2] use_bits);
      issue_valid     = 1'b1;
      issue_reg_write = rw;
      issue_rt_addr   = rt;
      issue_use       = use_bits;
   endtask

   // Settle mid-cycle, check, clock, then advance the model.
   task automatic step();
      logic acc;
      #4;
      check_model();
      acc = issue_valid && !flush && !m_stall();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 128; i++) begin
            mem[i] = '0;
            due[i] = -1;
         end
      end else begin
         if (wb_reg_write) mem[wb_rt_addr] = wb_rt;
         if (acc && issue_reg_write) due[issue_rt_addr] = cyc + L;
      end
      cyc++;
      #1;
   endtask

   logic [0:127] d1;
   logic [0:127] d2;

   initial begin
      vecs = 0;
      errs = 0;
      cyc  = 0;
      for (int i = 0; i < 128; i++) begin
         mem[i] = 'x;
         due[i] = -1;
      end
      idle();
      reset = 1'b1;
      #1;
      step();
      step();
      idle();
      #4;
      chk("rst_stall", 128'(stall), 128'(1'b0));
      chk("rst_busy", 128'(busy_any), 128'(1'b0));
      chk("rst_ra", ra, 128'd0);
      step();

      // Write then read, with same-cycle bypass.
      d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
      wb_reg_write = 1'b1;
      wb_rt_addr   = 7'd5;
      wb_rt        = d1;
      ra_addr      = 7'd5;
      #4;
      chk("bypass_ra", ra, d1);
      step();
      idle();
      ra_addr = 7'd5;
      #4;
      chk("read_ra", ra, d1);
      step();

      // RAW hazard on r7.
      idle();
      issue(7'd7, 1'b1, 3'b000);
      step();
      for (int k = 1; k <= 3; k++) begin
         idle();
         issue(7'd0, 1'b0, 3'b100);
         ra_addr = 7'd7;
         #4;
         chk("raw_stall", 128'(stall), 128'(1'b1));
         step();
      end
      d2 = {$urandom, $urandom, $urandom, $urandom};
      wb_reg_write = 1'b1;
      wb_rt_addr   = 7'd7;
      wb_rt        = d2;
      #4;
      chk("raw_go", 128'(stall), 128'(1'b0));
      chk("raw_ra", ra, d2);
      step();

      // Unused source does not stall.
      idle();
      issue(7'd7, 1'b1, 3'b000);
      step();
      idle();
      issue(7'd0, 1'b0, 3'b010);
      ra_addr = 7'd7;
      rb_addr = 7'd9;
      #4;
      chk("unused_stall", 128'(stall), 128'(1'b0));
      step();
      idle();
      for (int k = 0; k < 5; k++) step();

      // Flushed issue leaves no trace.
      issue(7'd3, 1'b1, 3'b000);
      flush = 1'b1;
      #4;
      chk("flush_stall", 128'(stall), 128'(1'b0));
      step();
      idle();
      issue(7'd0, 1'b0, 3'b100);
      ra_addr = 7'd3;
      #4;
      chk("flush_busy", 128'(busy_any), 128'(1'b0));
      chk("flush_rd", 128'(stall), 128'(1'b0));
      step();

      // WAW on r4 at T and T+2.
      idle();
      issue(7'd4, 1'b1, 3'b000);
      step();
      idle();
      step();
      issue(7'd4, 1'b1, 3'b000);
      step();
      for (int k = 3; k <= 5; k++) begin
         idle();
         issue(7'd0, 1'b0, 3'b001);
         rc_addr = 7'd4;
         #4;
         chk("waw_stall", 128'(stall), 128'(1'b1));
         step();
      end
      #4;
      chk("waw_go", 128'(stall), 128'(1'b0));
      chk("waw_busy6", 128'(busy_any), 128'(1'b1));
      step();
      idle();
      #4;
      chk("waw_busy7", 128'(busy_any), 128'(1'b0));
      step();

      // Reset while r2 is pending.
      wb_reg_write = 1'b1;
      wb_rt_addr   = 7'd2;
      wb_rt        = d1;
      step();
      idle();
      issue(7'd2, 1'b1, 3'b000);
      step();
      idle();
      step();
      reset = 1'b1;
      issue(7'd2, 1'b1, 3'b000);
      step();
      idle();
      ra_addr = 7'd2;
      #4;
      chk("rst_mid_busy", 128'(busy_any), 128'(1'b0));
      chk("rst_mid_ra", ra, 128'd0);
      step();

      // Random traffic on a small register window to provoke hazards.
      for (int n = 0; n < 600; n++) begin
         idle();
         reset           = ($urandom_range(0, 63) == 0);
         issue_valid     = $urandom_range(0, 1);
         issue_reg_write = $urandom_range(0, 1);
         issue_rt_addr   = 7'($urandom_range(0, 7));
         issue_use       = 3'($urandom);
         ra_addr         = 7'($urandom_range(0, 9));
         rb_addr         = 7'($urandom_range(0, 9));
         rc_addr         = 7'($urandom_range(0, 9));
         flush           = ($urandom_range(0, 7) == 0);
         wb_reg_write    = $urandom_range(0, 1);
         wb_rt_addr      = 7'($urandom_range(0, 9));
         wb_rt           = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/spu_wb_regfile.md
SPU_WB_REGFILE -- requirements
Module: spu_wb_regfile

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning the number of cycles from issue until the execution unit's writeback is presented; legal range 1..7.
REQ-002 SHALL have port clk, input, 1 bit, meaning the clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-004 SHALL have port issue_valid, input, 1 bit, meaning an instruction is presented for issue this cycle.
REQ-005 SHALL have port issue_reg_write, input, 1 bit, meaning the presented instruction writes rt.
REQ-006 SHALL have port issue_rt_addr, input, 7 bits [0:6], meaning the destination of the presented instruction.
REQ-007 SHALL have port issue_use, input, 3 bits [0:2], meaning bits 0/1/2 mark ra/rb/rc as real sources.
REQ-008 SHALL have ports ra_addr, rb_addr and rc_addr, input, 7 bits [0:6] each, meaning the source register addresses.
REQ-009 SHALL have port flush, input, 1 bit, meaning a branch was taken and the presented instruction is discarded.
REQ-010 SHALL have ports wb_rt (input, 128 bits [0:127]), wb_rt_addr (input, 7 bits [0:6]) and wb_reg_write (input, 1 bit), meaning the execution-unit writeback port.
REQ-011 SHALL have ports ra, rb and rc, output, 128 bits [0:127] each, meaning the source operand values.
REQ-012 SHALL have port stall, output, 1 bit, meaning the presented instruction is not accepted this cycle.
REQ-013 SHALL have port busy_any, output, 1 bit, meaning at least one write is pending.

Function
REQ-014 SHALL hold 128 registers of 128 bits each; register 0 is an ordinary, writable register.
REQ-015 SHALL write wb_rt into regs[wb_rt_addr] at the clock edge when wb_reg_write=1 and reset=0.
REQ-016 SHALL drive each read output combinationally:
- when wb_reg_write=1 and wb_rt_addr equals that source address: wb_rt (same-cycle bypass);
- otherwise: the stored register value.
REQ-017 SHALL keep a 3-bit countdown cnt[r] per register; every nonzero counter decrements by 1 each cycle.
REQ-018 SHALL assert stall combinationally when issue_valid=1, flush=0, and any source with its issue_use bit set has cnt>1.
- cnt=1 means the writeback is present this cycle and is covered by REQ-016.
REQ-019 SHALL accept an issue when issue_valid=1, stall=0 and flush=0; stall SHALL be 0 whenever issue_valid=0 or flush=1.
REQ-020 SHALL load cnt[issue_rt_addr] with LATENCY on an accepted issue with issue_reg_write=1.
- This overrides the decrement.
- A write-after-write to a busy register reloads the counter with LATENCY.
REQ-021 SHALL make no scoreboard change for a flushed instruction; writebacks already in flight SHALL still commit.
REQ-022 SHALL not check wb_reg_write against the scoreboard; writes to non-pending registers commit normally.
REQ-023 SHALL assert busy_any exactly when any cnt is nonzero.
REQ-024 SHALL allow a simultaneous accepted issue and writeback to the same register: the write commits and cnt reloads to LATENCY.

Reset
REQ-025 SHALL, on a clock edge with reset=1, clear all 128 registers and all counters to 0, and ignore issue and writeback in that cycle.
REQ-026 SHALL, after reset, drive stall=0, busy_any=0 and ra/rb/rc=0 until written.
REQ-027 SHALL make no state change before the reset edge when reset is asserted mid-operation; pending writes are forgotten once reset takes effect.

Verification
REQ-028 Write and read: wb_reg_write=1, addr 5, data 128'h0123...EF (one cycle), then ra_addr=5 -> ra=128'h0123...EF; same-cycle read of addr 5 also shows the bypassed value.
REQ-029 RAW hazard: issue rt=7 (reg_write=1) at cycle T, next issue uses ra=7 -> stall=1 in cycles T+1..T+3, stall=0 in cycle T+4 with wb of addr 7 present, and ra equals wb_rt.
REQ-030 Unused source: same as REQ-029 but issue_use=3'b010 with rb=9 (idle) -> stall=0 at T+1.
REQ-031 Flush: issue rt=3 with flush=1 -> cnt[3] stays 0, busy_any=0, and a following reader of r3 does not stall.
REQ-032 WAW: issue rt=4 at T and again at T+2 -> stall for a reader of r4 persists through T+5, and busy_any drops after T+6.
REQ-033 Reset mid-flight: issue rt=2, assert reset at T+2 -> busy_any=0 and ra(r2)=0 the cycle after reset is released.
